// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared state encoding and address helpers for the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Byte offset bits inside a line of 32-bit words
    function automatic int unsigned line_off(input int unsigned line_words);
        return clog2(line_words) + 2;
    endfunction

    function automatic logic line_match(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned off);
        return ((a ^ b) >> off) == 64'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority picker; search starts just after i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_valid
);

    int unsigned w_cand;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_valid   = 1'b0;
        w_cand    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_gnt_idx        = IDX_W'(w_cand);
                o_gnt_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Grants the external memory port to one cache line-transfer client per burst.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_REQ-1:0]          Req,
    input  logic [NUM_REQ-1:0]          Req_RW,
    input  logic [NUM_REQ*ADDR_W-1:0]   Req_Addr,
    output logic [NUM_REQ-1:0]          Gnt,
    output logic                        Port_Start,
    output logic                        Port_RW,
    output logic [ADDR_W-1:0]           Port_Addr,
    input  logic                        Beat,
    output logic [clog2(LINE_WORDS)-1:0] Beat_Count,
    output logic                        Busy
);

    localparam int unsigned        BC_W      = clog2(LINE_WORDS);
    localparam int unsigned        LOFF      = line_off(LINE_WORDS);
    localparam int unsigned        IDX_W     = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam logic [BC_W-1:0]    LAST_BEAT = BC_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]  LINE_MASK = {ADDR_W{1'b1}} << LOFF;

    logic [1:0]         state_q,     state_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]   win_idx_q,   win_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic               port_rw_q,   port_rw_d;
    logic [ADDR_W-1:0]  port_addr_q, port_addr_d;
    logic [BC_W-1:0]    beat_cnt_q,  beat_cnt_d;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic [ADDR_W-1:0]  w_pick_addr;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_hz_found;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (Req),
        .i_ptr     (rr_ptr_q),
        .o_gnt_oh  (w_pick_oh),
        .o_gnt_idx (w_pick_idx),
        .o_valid   (w_pick_vld)
    );

    assign w_pick_addr = Req_Addr[32'(w_pick_idx)*ADDR_W +: ADDR_W];

    // A pending write-back to the same line must reach memory before a refill reads it
    always_comb begin
        w_win_oh   = w_pick_oh;
        w_win_idx  = w_pick_idx;
        w_hz_found = 1'b0;
        if (!Req_RW[w_pick_idx]) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_hz_found && Req[i] && Req_RW[i] &&
                    line_match(64'(Req_Addr[i*ADDR_W +: ADDR_W]), 64'(w_pick_addr), LOFF)) begin
                    w_hz_found = 1'b1;
                    w_win_idx  = IDX_W'(i);
                    w_win_oh   = NUM_REQ'(1) << i;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        win_idx_d   = win_idx_q;
        rr_ptr_d    = rr_ptr_q;
        port_rw_d   = port_rw_q;
        port_addr_d = port_addr_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    gnt_d       = w_win_oh;
                    win_idx_d   = w_win_idx;
                    port_rw_d   = Req_RW[w_win_idx];
                    port_addr_d = Req_Addr[32'(w_win_idx)*ADDR_W +: ADDR_W] & LINE_MASK;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                beat_cnt_d = '0;
                state_d    = ST_BURST;
            end
            ST_BURST: begin
                if (Beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = win_idx_q;
                        state_d    = ST_TURN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            win_idx_q   <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            port_rw_q   <= 1'b0;
            port_addr_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            win_idx_q   <= win_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            port_rw_q   <= port_rw_d;
            port_addr_q <= port_addr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign Gnt        = gnt_q;
    assign Port_Start = (state_q == ST_GRANT);
    assign Port_RW    = port_rw_q;
    assign Port_Addr  = port_addr_q;
    assign Beat_Count = beat_cnt_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire
